axis_packet_arbiter: RTL

//  Shares one 256-bit AXI-Stream output among NUM_SRC packet sources (e.g. several

---
 rtl/axis_packet_arbiter.sv | 110 +++++++++++
 1 files changed

// File: rtl/axis_packet_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream output among NUM_SRC sources.
// Define AXIS_ARB_FIXED_PRIO_EN to switch to fixed priority (lowest index wins).
module axis_packet_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int DATA_W  = 256,
  parameter int KEEP_W  = 32
) (
  input  logic                      clk,
  input  logic                      resentn,
  input  logic [NUM_SRC*DATA_W-1:0] s_tdata,
  input  logic [NUM_SRC*KEEP_W-1:0] s_tkeep,
  input  logic [NUM_SRC-1:0]        s_tvalid,
  input  logic [NUM_SRC-1:0]        s_tlast,
  output logic [NUM_SRC-1:0]        s_tready,
  output logic [DATA_W-1:0]         m_tdata,
  output logic [KEEP_W-1:0]         m_tkeep,
  output logic                      m_tvalid,
  output logic                      m_tlast,
  input  logic                      m_tready,
  output logic [NUM_SRC-1:0]        grant,
  output logic [15:0]               pkt_count
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q;
  logic [NUM_SRC-1:0] grant_q;
  logic [IDX_W-1:0]   owner_q;
  logic [15:0]        pkt_count_q;
`ifndef AXIS_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]   last_grant_q;
`endif

  logic             win_vld_d;
  logic [IDX_W-1:0] win_idx_d;
  int               cand;

  // Winner search: first requesting index from the start point, wrapping
  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = '0;
    cand      = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
`ifdef AXIS_ARB_FIXED_PRIO_EN
      cand = i;
`else
      cand = (int'(last_grant_q) + 1 + i) % NUM_SRC;
`endif
      if (!win_vld_d && s_tvalid[cand]) begin
        win_vld_d = 1'b1;
        win_idx_d = IDX_W'(cand);
      end
    end
  end

  // Zero-latency output mux; everything is quiet while IDLE
  always_comb begin
    m_tdata  = '0;
    m_tkeep  = '0;
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
    s_tready = '0;
    if (state_q == BUSY) begin
      m_tdata           = s_tdata[int'(owner_q)*DATA_W +: DATA_W];
      m_tkeep           = s_tkeep[int'(owner_q)*KEEP_W +: KEEP_W];
      m_tvalid          = s_tvalid[owner_q];
      m_tlast           = s_tlast[owner_q];
      s_tready[owner_q] = m_tready;
    end
  end

  always_ff @(posedge clk or negedge resentn) begin
    if (!resentn) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      owner_q      <= '0;
      pkt_count_q  <= '0;
`ifndef AXIS_ARB_FIXED_PRIO_EN
      last_grant_q <= IDX_W'(NUM_SRC - 1);
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (win_vld_d) begin
            grant_q      <= NUM_SRC'(1) << win_idx_d;
            owner_q      <= win_idx_d;
`ifndef AXIS_ARB_FIXED_PRIO_EN
            last_grant_q <= win_idx_d;
`endif
            state_q      <= BUSY;
          end
        end
        BUSY: begin
          if (m_tvalid && m_tready && m_tlast) begin
            pkt_count_q <= pkt_count_q + 16'd1;
            grant_q     <= '0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant     = grant_q;
  assign pkt_count = pkt_count_q;

endmodule
